pc_shot_controller: RTL and testbench
=====================================

// Module: pc_shot_controller
// PURPOSE
// Sequences the PC's move while the game FSM is in PC_TURN. Waits a think delay, then picks a pseudo-random
// not-yet-shot cell of the player board and reads it. It writes HIT/MISS back, tracks remaining player ship cells,
// and returns pc_has_move / player_ships_zero to the game FSM. Sole owner of the player-board RAM port in PC_TURN.
// PARAMETERS
// GRID_N      5      board side; cells = GRID_N*GRID_N, addr = row*GRID_N+col
// THINK_CYC   50     clocks in THINK before first pick (0 allowed = skip)
// MAX_RETRY   8      random picks that hit already-shot cells before falling back to linear scan
// LFSR_SEED   8'hA5  LFSR reset value, must be nonzero
// PORTS (ADDR_W = $clog2(GRID_N*GRID_N), CNT_W = $clog2(GRID_N*GRID_N+1))
// clk               in   1       system clock
// rst               in   1       synchronous active-low reset, sampled on clk
// pc_turn_State     in   1       level from game FSM; high = PC may act
// load_cells        in   1       pulse: load ship_cells_init into remaining-cell counter, arm zero flag
// ship_cells_init   in   CNT_W   number of player ship cells placed
// rd_en             out  1       board read strobe; rd_data valid exactly 1 clk later
// rd_addr           out  ADDR_W  board read address
// rd_data           in   2       cell_t of rd_addr
// wr_en             out  1       board write strobe, 1-clk pulse
// wr_addr           out  ADDR_W  board write address
// wr_data           out  2       cell_t written (CELL_HIT or CELL_MISS)
// pc_has_move       out  1       1-clk pulse: move complete
// last_hit          out  1       1 = last completed shot was a hit; holds until next shot
// player_ships_zero out  1       level: armed && remaining==0
// board_full        out  1       sticky: scan found no unshot cell
// BEHAVIOUR
// - Reset (rst==0 at clk edge): state IDLE, all outputs 0, counter 0, disarmed, retry 0, LFSR=LFSR_SEED.
// - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk regardless of state.
// - States:
//   IDLE  -> THINK when pc_turn_State==1 and player_ships_zero==0.
//   THINK -> counts THINK_CYC clks, then PICK.
//   PICK  -> cand=lfsr[ADDR_W-1:0]; if cand>=GRID_N*GRID_N stay; else rd_en=1, rd_addr=cand, -> CHECK.
//   CHECK -> rd_data=CELL_SHIP: WRITE(HIT); CELL_EMPTY: WRITE(MISS).
//            CELL_HIT/CELL_MISS: retry+1; if retry<MAX_RETRY -> PICK, else -> SCAN with ptr=cand+1 (wrap).
//   SCAN  -> read ptr, -> SCHK.
//   SCHK  -> free cell -> WRITE; else ptr+1 mod cells -> SCAN.
//            Full lap back to the start cell without a free cell -> set board_full -> DONE, no write.
//   WRITE -> wr_en=1 for one clk; set last_hit; on HIT decrement counter (saturate at 0) -> DONE.
//   DONE  -> pc_has_move=1 for exactly one clk; retry cleared; -> WAIT.
//   WAIT  -> stays until pc_turn_State==0, then IDLE. Exactly one move per PC_TURN entry.
// - pc_turn_State falling in THINK/PICK/CHECK/SCAN/SCHK: abort to IDLE next clk.
//   No write, no pulse, outstanding read discarded.
//   WRITE is never aborted: the write and the following pc_has_move pulse both complete.
// - load_cells: counter <= ship_cells_init, armed <= 1. Takes priority over a same-clk HIT decrement.
//   Accepted in any state.
// - player_ships_zero combinational from registers, valid the clk after the decrement to 0.
//   It is asserted in the same clk as the final pc_has_move pulse.
// - Random-path latency (THINK_CYC=0, first pick valid): IDLE->THINK->PICK->CHECK->WRITE->DONE.
//   pc_has_move fires 5 clks after pc_turn_State rises.
// - rd_en and wr_en are never high in the same clk. The board port is idle outside PICK/SCAN/WRITE.
// STRUCTURE
// - battleship_pkg: cell_t enum logic[1:0] {CELL_EMPTY=00, CELL_SHIP=01, CELL_HIT=10, CELL_MISS=11}.
//   Also GRID_N default and the pc_shot state enum.
// - Sub-module lfsr8 (clk, rst, seed param, q[7:0]) instantiated once; the rest is a single FSM plus counters.
// TESTING
// - Reset mid-THINK: rst=0 one clk -> all outputs 0, state IDLE, no wr_en ever.
// - Empty board, THINK_CYC=0, load 3 cells, pc_turn 1 -> one wr_en with MISS, pc_has_move 5 clks after rise, last_hit=0.
// - Board all CELL_SHIP, load 1 -> wr HIT, counter 0; player_ships_zero=1 and pc_has_move pulse in same clk.
// - 24 cells MISS, addr 17 EMPTY, MAX_RETRY=2 -> scan reaches 17, wr_addr=17, wr_data=MISS, exactly one write.
// - All 25 cells shot -> board_full=1, pc_has_move pulses, wr_en never high.
// - pc_turn drops during THINK -> IDLE; re-raise -> exactly one move, no duplicate pulse.

Source files
------------

// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared board cell encoding, grid default and PC shot FSM states
package battleship_pkg;

  localparam int GRID_N_DEFAULT = 5;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_HIT   = 2'b10,
    CELL_MISS  = 2'b11
  } cell_t;

  typedef enum logic [3:0] {
    PS_IDLE  = 4'd0,
    PS_THINK = 4'd1,
    PS_PICK  = 4'd2,
    PS_CHECK = 4'd3,
    PS_SCAN  = 4'd4,
    PS_SCHK  = 4'd5,
    PS_WRITE = 4'd6,
    PS_DONE  = 4'd7,
    PS_WAIT  = 4'd8
  } pc_state_t;

  // A cell the PC may still fire at: never shot, with or without a ship.
  function automatic logic cell_is_free(input logic [1:0] c);
    return (c == CELL_EMPTY) || (c == CELL_SHIP);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign q  = lfsr_q;

  // Shift every clock; reload the seed on reset so the sequence is repeatable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
    end
  end

endmodule

// File: rtl/pc_shot_controller.sv
// rtl/pc_shot_controller.sv - sequences one PC shot per PC turn on the player board port
module pc_shot_controller
  import battleship_pkg::*;
#(
  parameter int         GRID_N    = GRID_N_DEFAULT,
  parameter int         THINK_CYC = 50,
  parameter int         MAX_RETRY = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  localparam int        CELLS     = GRID_N * GRID_N,
  localparam int        ADDR_W    = $clog2(CELLS),
  localparam int        CNT_W     = $clog2(CELLS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_turn_State,
  input  logic              load_cells,
  input  logic [CNT_W-1:0]  ship_cells_init,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              pc_has_move,
  output logic              last_hit,
  output logic              player_ships_zero,
  output logic              board_full
);

  localparam int                TW         = (THINK_CYC > 1) ? $clog2(THINK_CYC) : 1;
  localparam logic [TW-1:0]     THINK_LAST = TW'((THINK_CYC > 0) ? THINK_CYC - 1 : 0);
  localparam int                RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]     RETRY_LIM  = RW'(MAX_RETRY);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_X    = (ADDR_W + 1)'(CELLS);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     think_q, think_d;
  logic              hit_q, hit_d;
  logic              last_hit_q, last_hit_d;
  logic              board_full_q, board_full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;

  logic [7:0]        lfsr_val;
  logic [ADDR_W-1:0] cand;
  logic              cand_ok;
  logic [ADDR_W-1:0] tgt_next;
  logic [RW-1:0]     retry_inc;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_val)
  );

  assign cand              = lfsr_val[ADDR_W-1:0];
  assign cand_ok           = {1'b0, cand} < CELLS_X;
  assign tgt_next          = (tgt_q == LAST_CELL) ? '0 : tgt_q + 1'b1;
  assign retry_inc         = retry_q + 1'b1;
  assign player_ships_zero = armed_q && (cnt_q == '0);
  assign last_hit          = last_hit_q;
  assign board_full        = board_full_q;

  // State, shot target, retry/think counters and the remaining-ship bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= PS_IDLE;
      tgt_q        <= '0;
      start_q      <= '0;
      retry_q      <= '0;
      think_q      <= '0;
      hit_q        <= 1'b0;
      last_hit_q   <= 1'b0;
      board_full_q <= 1'b0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      start_q      <= start_d;
      retry_q      <= retry_d;
      think_q      <= think_d;
      hit_q        <= hit_d;
      last_hit_q   <= last_hit_d;
      board_full_q <= board_full_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
    end
  end

  // Next state and board-port strobes; losing the turn aborts anything before WRITE.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    start_d      = start_q;
    retry_d      = retry_q;
    think_d      = think_q;
    hit_d        = hit_q;
    last_hit_d   = last_hit_q;
    board_full_d = board_full_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    rd_en        = 1'b0;
    rd_addr      = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = CELL_EMPTY;
    pc_has_move  = 1'b0;

    unique case (state_q)
      PS_IDLE: begin
        retry_d = '0;
        think_d = '0;
        if (pc_turn_State && !player_ships_zero) begin
          state_d = PS_THINK;
        end
      end
      PS_THINK: begin
        if (!pc_turn_State) begin
          state_d = PS_IDLE;
        end else if (THINK_CYC <= 1 || think_q == THINK_LAST) begin
          state_d = PS_PICK;
        end else begin
          think_d = think_q + 1'b1;
        end
      end
      PS_PICK: begin
        if (!pc_turn_State) begin
          state_d = PS_IDLE;
        end else if (cand_ok) begin
          rd_en   = 1'b1;
          rd_addr = cand;
          tgt_d   = cand;
          state_d = PS_CHECK;
        end
      end
      PS_CHECK: begin
        if (!pc_turn_State) begin
          state_d = PS_IDLE;
        end else if (cell_is_free(rd_data)) begin
          hit_d   = (rd_data == CELL_SHIP);
          state_d = PS_WRITE;
        end else begin
          retry_d = retry_inc;
          if (retry_inc < RETRY_LIM) begin
            state_d = PS_PICK;
          end else begin
            // Too many repeats: walk the board from just past the last pick.
            start_d = tgt_next;
            tgt_d   = tgt_next;
            state_d = PS_SCAN;
          end
        end
      end
      PS_SCAN: begin
        if (!pc_turn_State) begin
          state_d = PS_IDLE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = tgt_q;
          state_d = PS_SCHK;
        end
      end
      PS_SCHK: begin
        if (!pc_turn_State) begin
          state_d = PS_IDLE;
        end else if (cell_is_free(rd_data)) begin
          hit_d   = (rd_data == CELL_SHIP);
          state_d = PS_WRITE;
        end else if (tgt_next == start_q) begin
          board_full_d = 1'b1;
          state_d      = PS_DONE;
        end else begin
          tgt_d   = tgt_next;
          state_d = PS_SCAN;
        end
      end
      PS_WRITE: begin
        wr_en      = 1'b1;
        wr_addr    = tgt_q;
        wr_data    = hit_q ? CELL_HIT : CELL_MISS;
        last_hit_d = hit_q;
        if (hit_q && cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        state_d = PS_DONE;
      end
      PS_DONE: begin
        pc_has_move = 1'b1;
        retry_d     = '0;
        state_d     = PS_WAIT;
      end
      PS_WAIT: begin
        if (!pc_turn_State) begin
          state_d = PS_IDLE;
        end
      end
      default: begin
        state_d = PS_IDLE;
      end
    endcase

    // A fresh ship count overrides any decrement in the same cycle.
    if (load_cells) begin
      cnt_d   = ship_cells_init;
      armed_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_shot_controller.sv
// tb/tb_pc_shot_controller.sv - randomized self-checking bench for pc_shot_controller
module tb_pc_shot_controller;
  import battleship_pkg::*;

  localparam int NCELL = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pc_turn_State = 1'b0;
  logic       load_cells = 1'b0;
  logic [4:0] ship_cells_init = '0;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [1:0] rd_data = 2'b00;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [1:0] wr_data;
  logic       pc_has_move;
  logic       last_hit;
  logic       player_ships_zero;
  logic       board_full;

  int checks = 0;
  int failures = 0;

  logic [1:0] mem [NCELL];
  logic [1:0] init_img [NCELL];
  logic [1:0] model [NCELL];
  logic       init_req = 1'b0;

  int         wr_cnt = 0;
  int         pulse_cnt = 0;
  int         overlap_cnt = 0;
  logic [4:0] last_wr_addr = '0;
  logic [1:0] last_wr_data = '0;
  logic [7:0] m_lfsr = 8'hA5;

  pc_shot_controller #(
    .GRID_N    (5),
    .THINK_CYC (0),
    .MAX_RETRY (2),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_turn_State     (pc_turn_State),
    .load_cells        (load_cells),
    .ship_cells_init   (ship_cells_init),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .pc_has_move       (pc_has_move),
    .last_hit          (last_hit),
    .player_ships_zero (player_ships_zero),
    .board_full        (board_full)
  );

  always #5 clk = ~clk;

  // Polynomial x^8+x^6+x^5+x^4+1 as a Fibonacci shift.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Board RAM with one-cycle read latency, plus an observer of the port and pulse.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= init_img[i];
    end else if (wr_en && wr_addr < NCELL) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en && rd_addr < NCELL) rd_data <= mem[rd_addr];
    m_lfsr <= !rst ? 8'hA5 : lfsr_step(m_lfsr);
    if (wr_en) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (pc_has_move) pulse_cnt <= pulse_cnt + 1;
    if (rd_en && wr_en) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pc_turn_State = 1'b0;
    load_cells = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_board();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    for (int i = 0; i < NCELL; i++) model[i] = init_img[i];
  endtask

  task automatic load_count(input int n);
    @(negedge clk);
    load_cells = 1'b1;
    ship_cells_init = 5'(n);
    @(negedge clk);
    load_cells = 1'b0;
  endtask

  // One PC turn; predicts latency and first in-range pick from the LFSR polynomial.
  task automatic run_move(input string name, input int budget, input int hold,
                          output int lat, output int exp_lat, output logic [4:0] exp_addr,
                          output logic psz);
    logic [7:0] v;
    int extra;
    bit got;
    @(negedge clk);
    v = lfsr_step(lfsr_step(m_lfsr));
    extra = 0;
    for (int i = 0; i < 300 && v[4:0] >= NCELL; i++) begin
      v = lfsr_step(v);
      extra++;
    end
    exp_lat = 5 + extra;
    exp_addr = v[4:0];
    pc_turn_State = 1'b1;
    lat = 0;
    got = 1'b0;
    psz = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (pc_has_move) begin
        got = 1'b1;
        psz = player_ships_zero;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: no pc_has_move within %0d clks, required a pulse", name, budget);
    end
    repeat (hold) @(negedge clk);
    @(negedge clk);
    pc_turn_State = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int w0, p0;
    do_reset();
    #1;
    checks++;
    if ({rd_en, wr_en, pc_has_move, last_hit, player_ships_zero, board_full} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {rd_en, wr_en, pc_has_move, last_hit, player_ships_zero, board_full});
    end
    for (int i = 0; i < NCELL; i++) init_img[i] = CELL_EMPTY;
    load_board();
    load_count(3);
    w0 = wr_cnt;
    p0 = pulse_cnt;
    @(negedge clk);
    pc_turn_State = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pc_turn_State = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({rd_en, wr_en, pc_has_move, last_hit, player_ships_zero, board_full} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_think: outputs %b required 000000",
               {rd_en, wr_en, pc_has_move, last_hit, player_ships_zero, board_full});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || pulse_cnt != p0) begin
      failures++;
      $display("FAIL reset_no_activity: writes %0d pulses %0d required 0 0", wr_cnt - w0, pulse_cnt - p0);
    end
  endtask

  task automatic test_empty_miss();
    int w0, p0, lat, el;
    logic [4:0] ea;
    logic psz;
    do_reset();
    for (int i = 0; i < NCELL; i++) init_img[i] = CELL_EMPTY;
    load_board();
    load_count(3);
    w0 = wr_cnt;
    p0 = pulse_cnt;
    run_move("empty", 100, 0, lat, el, ea, psz);
    checks++;
    if (lat != el) begin
      failures++;
      $display("FAIL empty_latency: got %0d clks required %0d", lat, el);
    end
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_data !== CELL_MISS || last_wr_addr !== ea) begin
      failures++;
      $display("FAIL empty_write: n=%0d addr=%0d data=%b required n=1 addr=%0d data=11",
               wr_cnt - w0, last_wr_addr, last_wr_data, ea);
    end
    checks++;
    if (last_hit !== 1'b0 || psz !== 1'b0 || pulse_cnt - p0 != 1) begin
      failures++;
      $display("FAIL empty_flags: last_hit=%b zero=%b pulses=%0d required 0 0 1",
               last_hit, psz, pulse_cnt - p0);
    end
  endtask

  task automatic test_all_ship();
    int w0, p0, lat, el;
    logic [4:0] ea;
    logic psz;
    do_reset();
    for (int i = 0; i < NCELL; i++) init_img[i] = CELL_SHIP;
    load_board();
    load_count(1);
    w0 = wr_cnt;
    p0 = pulse_cnt;
    run_move("ship", 100, 0, lat, el, ea, psz);
    checks++;
    if (lat != el || psz !== 1'b1) begin
      failures++;
      $display("FAIL ship_zero_with_pulse: lat=%0d zero=%b required lat=%0d zero=1", lat, psz, el);
    end
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_data !== CELL_HIT || last_wr_addr !== ea || last_hit !== 1'b1) begin
      failures++;
      $display("FAIL ship_write: n=%0d addr=%0d data=%b hit=%b required n=1 addr=%0d data=10 hit=1",
               wr_cnt - w0, last_wr_addr, last_wr_data, last_hit, ea);
    end
    @(negedge clk);
    pc_turn_State = 1'b1;
    repeat (20) @(negedge clk);
    pc_turn_State = 1'b0;
    checks++;
    if (pulse_cnt - p0 != 1 || wr_cnt - w0 != 1) begin
      failures++;
      $display("FAIL ship_no_move_after_zero: pulses=%0d writes=%0d required 1 1", pulse_cnt - p0, wr_cnt - w0);
    end
  endtask

  task automatic test_scan();
    int w0, lat, el;
    logic [4:0] ea;
    logic psz;
    do_reset();
    for (int i = 0; i < NCELL; i++) init_img[i] = CELL_MISS;
    init_img[17] = CELL_EMPTY;
    load_board();
    load_count(2);
    w0 = wr_cnt;
    run_move("scan", 600, 0, lat, el, ea, psz);
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_addr !== 5'd17 || last_wr_data !== CELL_MISS) begin
      failures++;
      $display("FAIL scan_write: n=%0d addr=%0d data=%b required n=1 addr=17 data=11",
               wr_cnt - w0, last_wr_addr, last_wr_data);
    end
    checks++;
    if (board_full !== 1'b0 || last_hit !== 1'b0) begin
      failures++;
      $display("FAIL scan_flags: board_full=%b last_hit=%b required 0 0", board_full, last_hit);
    end
  endtask

  task automatic test_abort();
    int w0, p0, lat, el;
    logic [4:0] ea;
    logic psz;
    do_reset();
    for (int i = 0; i < NCELL; i++) init_img[i] = CELL_EMPTY;
    load_board();
    load_count(3);
    w0 = wr_cnt;
    p0 = pulse_cnt;
    @(negedge clk);
    pc_turn_State = 1'b1;
    @(negedge clk);
    pc_turn_State = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || pulse_cnt != p0) begin
      failures++;
      $display("FAIL abort_think: writes=%0d pulses=%0d required 0 0", wr_cnt - w0, pulse_cnt - p0);
    end
    run_move("abort_retry", 100, 15, lat, el, ea, psz);
    checks++;
    if (wr_cnt - w0 != 1 || pulse_cnt - p0 != 1 || lat != el) begin
      failures++;
      $display("FAIL abort_one_move: writes=%0d pulses=%0d lat=%0d required 1 1 %0d",
               wr_cnt - w0, pulse_cnt - p0, lat, el);
    end
  endtask

  task automatic test_random(input int rounds);
    int ships, w0, lat, el;
    logic [4:0] ea;
    logic psz;
    logic [1:0] expd;
    for (int r = 0; r < rounds; r++) begin
      do_reset();
      ships = 0;
      for (int i = 0; i < NCELL; i++) init_img[i] = 2'($urandom_range(0, 3));
      init_img[$urandom_range(0, NCELL - 1)] = CELL_SHIP;
      for (int i = 0; i < NCELL; i++) if (init_img[i] == CELL_SHIP) ships++;
      load_board();
      load_count(ships);
      for (int mv = 0; mv < NCELL && ships > 0; mv++) begin
        w0 = wr_cnt;
        run_move("random", 600, 0, lat, el, ea, psz);
        expd = (last_wr_addr < NCELL && model[last_wr_addr] == CELL_SHIP) ? CELL_HIT : CELL_MISS;
        checks++;
        if (wr_cnt - w0 != 1 || last_wr_addr >= NCELL || !cell_is_free(model[last_wr_addr])
            || last_wr_data !== expd) begin
          failures++;
          $display("FAIL random_write: n=%0d addr=%0d data=%b required n=1 unshot cell data=%b",
                   wr_cnt - w0, last_wr_addr, last_wr_data, expd);
        end
        if (last_wr_addr < NCELL) begin
          if (model[last_wr_addr] == CELL_SHIP) ships--;
          model[last_wr_addr] = expd;
        end
        checks++;
        if (last_hit !== (expd == CELL_HIT) || psz !== (ships == 0)) begin
          failures++;
          $display("FAIL random_flags: last_hit=%b zero=%b required %b %b",
                   last_hit, psz, expd == CELL_HIT, ships == 0);
        end
      end
    end
  endtask

  task automatic test_board_full();
    int w0, p0, lat, el;
    logic [4:0] ea;
    logic psz;
    do_reset();
    for (int i = 0; i < NCELL; i++) init_img[i] = ($urandom_range(0, 1) == 0) ? CELL_HIT : CELL_MISS;
    load_board();
    load_count(2);
    w0 = wr_cnt;
    p0 = pulse_cnt;
    run_move("full", 600, 0, lat, el, ea, psz);
    checks++;
    if (board_full !== 1'b1 || pulse_cnt - p0 != 1) begin
      failures++;
      $display("FAIL full_flag: board_full=%b pulses=%0d required 1 1", board_full, pulse_cnt - p0);
    end
    checks++;
    if (wr_cnt != w0 || psz !== 1'b0 || last_hit !== 1'b0) begin
      failures++;
      $display("FAIL full_no_write: writes=%0d zero=%b last_hit=%b required 0 0 0",
               wr_cnt - w0, psz, last_hit);
    end
  endtask

  initial begin
    test_reset();
    test_empty_miss();
    test_all_ship();
    test_scan();
    test_abort();
    test_random(3);
    test_board_full();
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL port_overlap: rd_en&wr_en seen %0d clks required 0", overlap_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
